// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide unit. A single WIDTH+1-bit adder/subtractor
// performs one shift-add or restoring-subtract step per clock.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       ope_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] res_o,
    output logic             dbz_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [1:0]         op_reg;
    logic [CNT_W-1:0]   cnt_reg;
    // acc_hi_reg is the multiply high word (with room for the carry) or the
    // divide remainder; acc_lo_reg is the multiplier being consumed or the quotient.
    logic [WIDTH:0]     acc_hi_reg;
    logic [WIDTH-1:0]   acc_lo_reg;
    logic [WIDTH-1:0]   res_reg;
    logic               dbz_reg;

    logic               accept;
    logic               dbz_start;
    logic               last_iter;
    logic               is_div;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_b;
    logic [WIDTH+1:0]   add_sum;
    logic               trial_ok;
    logic [WIDTH:0]     hi_step;
    logic [WIDTH-1:0]   lo_step;
    logic [WIDTH-1:0]   result_step;

    // A start in DONE is a back-to-back request, unless a flush overrides it.
    assign accept    = start_i && ((state_reg == ST_IDLE) ||
                                   ((state_reg == ST_DONE) && !flush_i));
    assign dbz_start = ope_i[1] && (b_i == '0);
    assign last_iter = (state_reg == ST_CALC) && (cnt_reg == CNT_W'(WIDTH - 1));

    // Shared adder: subtracts for divide, adds (conditionally) for multiply.
    assign is_div    = op_reg[1];
    assign rem_shift = {acc_hi_reg[WIDTH-1:0], acc_lo_reg[WIDTH-1]};
    assign add_a     = is_div ? rem_shift : acc_hi_reg;
    assign add_b     = is_div ? {1'b0, b_reg}
                              : (acc_lo_reg[0] ? {1'b0, a_reg} : '0);
    assign add_sum   = {1'b0, add_a}
                     + {1'b0, (is_div ? ~add_b : add_b)}
                     + {{(WIDTH+1){1'b0}}, is_div};
    // Carry out of the subtraction means the trial remainder is non-negative.
    assign trial_ok  = add_sum[WIDTH+1];

    always_comb begin
        hi_step = acc_hi_reg;
        lo_step = acc_lo_reg;
        if (is_div) begin
            hi_step = trial_ok ? add_sum[WIDTH:0] : rem_shift;
            lo_step = {acc_lo_reg[WIDTH-2:0], trial_ok};
        end else begin
            hi_step = {1'b0, add_sum[WIDTH:1]};
            lo_step = {add_sum[0], acc_lo_reg[WIDTH-1:1]};
        end
    end

    // MUL/DIVU take the low register, MULHU/REMU the high one.
    assign result_step = op_reg[0] ? hi_step[WIDTH-1:0] : lo_step;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = dbz_start ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_next = ST_IDLE;
                end else if (last_iter) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush_i) begin
                    state_next = ST_IDLE;
                end else if (start_i) begin
                    state_next = dbz_start ? ST_DONE : ST_CALC;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = 1'b0;
        valid_o = 1'b0;
        case (state_reg)
            ST_CALC: busy_o  = 1'b1;
            ST_DONE: valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            cnt_reg    <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            res_reg    <= '0;
            dbz_reg    <= 1'b0;
        end else if (accept) begin
            a_reg      <= a_i;
            b_reg      <= b_i;
            op_reg     <= ope_i;
            cnt_reg    <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= ope_i[1] ? a_i : b_i;
            if (dbz_start) begin
                res_reg <= ope_i[0] ? a_i : '1;
                dbz_reg <= 1'b1;
            end
        end else if ((state_reg == ST_CALC) && !flush_i) begin
            acc_hi_reg <= hi_step;
            acc_lo_reg <= lo_step;
            cnt_reg    <= cnt_reg + CNT_W'(1);
            if (last_iter) begin
                res_reg <= result_step;
                dbz_reg <= 1'b0;
            end
        end
    end

    assign res_o = res_reg;
    assign dbz_o = dbz_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq at WIDTH=8, checked against
// plain integer multiply/divide arithmetic.
module tb_muldiv_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   ope;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         valid;
    logic [W-1:0] res;
    logic         dbz;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_res;
    logic         exp_dbz;
    int           exp_lat;
    logic [W-1:0] last_res;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .ope_i   (ope),
        .a_i     (a),
        .b_i     (b),
        .flush_i (flush),
        .busy_o  (busy),
        .valid_o (valid),
        .res_o   (res),
        .dbz_o   (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: full product and integer division straight from the operation table.
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        int unsigned prod;
        prod = int'(av) * int'(bv);
        exp_dbz = op[1] && (bv == 0);
        case (op)
            2'd0: exp_res = prod[7:0];
            2'd1: exp_res = prod[15:8];
            2'd2: exp_res = (bv == 0) ? 8'hFF : W'(int'(av) / int'(bv));
            default: exp_res = (bv == 0) ? av : W'(int'(av) % int'(bv));
        endcase
        exp_lat = exp_dbz ? 1 : W + 1;
        start = 1'b1;
        ope   = op;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for valid (bounded), scrambling operands; optionally pokes a start while busy.
    task automatic finish_op(input string tag, input int poke_at);
        int lat;
        lat = 1;
        check({tag, "_busy"}, 32'(busy), 32'(exp_lat > 1));
        if (exp_lat > 1) check({tag, "_hold"}, 32'(res), 32'(last_res));
        while (!valid && lat < 40) begin
            a   = W'($urandom);
            b   = W'($urandom);
            ope = 2'($urandom);
            start = (lat == poke_at);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, 32'(res), 32'(exp_res));
        check({tag, "_dbz"}, 32'(dbz), 32'(exp_dbz));
        $display("op=%0d tag=%s res=0x%0h dbz=%0d lat=%0d", ope, tag, res, dbz, lat);
        last_res = exp_res;
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_keep"}, 32'(res), 32'(last_res));
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv);
        start_op(op, av, bv);
        finish_op(tag, 0);
        expect_idle(tag);
    endtask

    initial begin
        int saw_valid;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        ope   = '0;
        a     = '0;
        b     = '0;
        last_res = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_res",   32'(res),   32'd0);
        check("rst_dbz",   32'(dbz),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("mul13",   2'd0, 8'd13,  8'd11);
        run("mulhu13", 2'd1, 8'd13,  8'd11);
        run("mul200",  2'd0, 8'd200, 8'd200);
        run("mulhu200",2'd1, 8'd200, 8'd200);
        run("divu200", 2'd2, 8'd200, 8'd7);
        run("remu200", 2'd3, 8'd200, 8'd7);
        run("divu5",   2'd2, 8'd5,   8'd9);
        run("remu5",   2'd3, 8'd5,   8'd9);
        run("divu0",   2'd2, 8'h5A,  8'd0);
        run("remu0",   2'd3, 8'h5A,  8'd0);
        run("mulmax",  2'd1, 8'hFF,  8'hFF);

        // Start while busy is ignored.
        start_op(2'd0, 8'd13, 8'd11);
        finish_op("poke", 3);
        expect_idle("poke");

        // Back-to-back: start held in DONE.
        start_op(2'd1, 8'd200, 8'd200);
        finish_op("b2b_a", 0);
        start_op(2'd2, 8'd200, 8'd7);
        finish_op("b2b_b", 0);
        start_op(2'd3, 8'd77, 8'd0);
        finish_op("b2b_c", 0);
        expect_idle("b2b");

        // Flush mid-CALC: no valid, result unchanged.
        start_op(2'd0, 8'd99, 8'd3);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        saw_valid = 0;
        repeat (12) begin
            if (valid) saw_valid = 1;
            @(negedge clk);
        end
        check("flush_noval", 32'(saw_valid), 32'd0);
        check("flush_busy",  32'(busy), 32'd0);
        check("flush_keep",  32'(res), 32'(last_res));

        // Asynchronous reset mid-CALC.
        start_op(2'd3, 8'd250, 8'd3);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",  32'(busy),  32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_res",   32'(res),   32'd0);
        check("arst_dbz",   32'(dbz),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        saw_valid = 0;
        repeat (12) begin
            if (valid) saw_valid = 1;
            @(negedge clk);
        end
        check("arst_noval", 32'(saw_valid), 32'd0);

        // Randomized operations against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]   rop;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            rop = 2'($urandom);
            ra  = W'($urandom);
            rb  = ($urandom_range(0, 5) == 0) ? '0 :
                  ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 15)) : W'($urandom);
            run("rand", rop, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative unsigned multiply/divide unit for the execute stage, filling the multiply and divide gap left by the bit-slice ALU.
- One shared WIDTH+1-bit adder/subtractor performs one shift-add (multiply) or restoring-subtract (divide) step per cycle.
- Sequenced by a small FSM with a start/busy/valid handshake toward the control unit.

Parameters:
WIDTH, 32, operand and result width in bits (≥4)
CNT_W, $clog2(WIDTH+1), width of the iteration counter

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  request; accepted only when busy_o=0
ope_i  input  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU (quotient), 11 REMU (remainder)
a_i  input  WIDTH  multiplicand / dividend, unsigned
b_i  input  WIDTH  multiplier / divisor, unsigned
flush_i  input  1  synchronous abort of an operation in flight
busy_o  output  1  operation in CALC
valid_o  output  1  one-cycle pulse, res_o valid
res_o  output  WIDTH  result; held until the next accepted start
dbz_o  output  1  divide-by-zero flag, qualified by valid_o

Behaviour:
- Reset (async, rst_ni=0): state IDLE, busy_o=0, valid_o=0, res_o=0, dbz_o=0, counter=0, internal accumulators=0. Effective immediately, including mid-operation; no valid_o follows.
- States:
  - IDLE: start_i -> capture a_i, b_i, ope_i; cnt=0 -> CALC. If the operation is a divide and b_i==0 -> DONE directly.
  - CALC: one iteration per edge, cnt++; the edge performing iteration WIDTH -> DONE.
  - DONE: valid_o=1 for exactly this cycle. start_i here is accepted (back-to-back) -> CALC, otherwise -> IDLE.
- busy_o=1 only in CALC. start_i while busy is ignored with no side effect.
- Latency: start sampled at edge k -> valid_o high in the cycle after edge k+WIDTH (WIDTH+1 cycles). Divide by zero: valid_o in the cycle after edge k+1... no: after edge k (1 cycle).
- Multiply: 2*WIDTH accumulator {hi,lo}, lo initialised to b.
  - Per step: if lo[0], hi+=a (WIDTH+1-bit carry kept).
  - Then shift {carry,hi,lo} right by 1.
  - MUL -> lo; MULHU -> hi. Full 2W product, no overflow flag.
- Divide (restoring): rem (WIDTH+1 bits)=0, quo=a.
  - Per step: {rem,quo} <<= 1; trial=rem-b.
  - If trial ≥0: rem=trial, quo[0]=1; else quo[0]=0.
  - DIVU -> quo; REMU -> rem[WIDTH-1:0].
- Divide by zero: res_o=all-ones for DIVU, a for REMU; dbz_o=1. dbz_o=0 for all other operations.
- res_o and dbz_o update only on entry to DONE. They hold through IDLE and CALC until the next DONE.
- flush_i in CALC or DONE -> IDLE next edge; valid_o suppressed; res_o keeps its previous value. flush_i has priority over start_i in the same cycle. flush_i in IDLE has no effect.
- Operands are captured at acceptance; a_i, b_i and ope_i changes during CALC have no effect.

Test Plan (WIDTH=8):
- MUL a=13, b=11 -> valid_o after 9 cycles, res_o=0x8F. Repeat with MULHU -> res_o=0x00, dbz_o=0.
- MUL/MULHU a=200, b=200 -> res_o=0x40, then 0x9C. Checks carry out of the hi add.
- DIVU a=200, b=7 -> res_o=28. REMU -> res_o=4. a=5, b=9: DIVU=0, REMU=5.
- DIVU a=0x5A, b=0 -> valid_o in the cycle after the start edge, res_o=0xFF, dbz_o=1. REMU -> res_o=0x5A, dbz_o=1.
- Second start_i pulsed at cycle 3 of CALC with different operands -> ignored, first result correct. start_i held high in DONE -> back-to-back op accepted, busy_o=1 next cycle.
- flush_i at cycle 4 of CALC -> IDLE, no valid_o, res_o unchanged. rst_ni low mid-CALC -> all outputs 0 asynchronously, no valid_o after release.
